// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Opcodes, ALU operation codes and FSM state encoding shared by
//               the multicycle control unit and its ALU decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_decoder
// Description : Maps opcode/funct3/funct7[5] to an ALU operation and a legal
//               flag. Unsupported encodings report illegal with ALUCtrl=ADD.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    output logic [3:0] alu_ctrl_o,
    output logic       legal_o
);

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        legal_o    = 1'b0;
        case (opcode_i)
            OP_R: begin
                legal_o = 1'b1;
                case (funct3_i)
                    3'b000: alu_ctrl_o = funct7b5_i ? ALU_SUB : ALU_ADD;
                    3'b001: begin alu_ctrl_o = ALU_SLL; legal_o = !funct7b5_i; end
                    3'b010: begin alu_ctrl_o = ALU_SLT; legal_o = !funct7b5_i; end
                    3'b011: legal_o = 1'b0;
                    3'b100: begin alu_ctrl_o = ALU_XOR; legal_o = !funct7b5_i; end
                    3'b101: alu_ctrl_o = funct7b5_i ? ALU_SRA : ALU_SRL;
                    3'b110: begin alu_ctrl_o = ALU_OR;  legal_o = !funct7b5_i; end
                    3'b111: begin alu_ctrl_o = ALU_AND; legal_o = !funct7b5_i; end
                    default: legal_o = 1'b0;
                endcase
            end
            OP_I: begin
                // Immediate bits overlap funct7, so only the shift-right pair looks at it
                legal_o = 1'b1;
                case (funct3_i)
                    3'b000: alu_ctrl_o = ALU_ADD;
                    3'b001: alu_ctrl_o = ALU_SLL;
                    3'b010: alu_ctrl_o = ALU_SLT;
                    3'b011: legal_o    = 1'b0;
                    3'b100: alu_ctrl_o = ALU_XOR;
                    3'b101: alu_ctrl_o = funct7b5_i ? ALU_SRA : ALU_SRL;
                    3'b110: alu_ctrl_o = ALU_OR;
                    3'b111: alu_ctrl_o = ALU_AND;
                    default: legal_o = 1'b0;
                endcase
            end
            OP_LOAD:   legal_o = (funct3_i == F3_LW);
            OP_STORE:  legal_o = (funct3_i == F3_SW);
            OP_BRANCH: begin
                alu_ctrl_o = ALU_SUB;
                legal_o    = (funct3_i == F3_BEQ);
            end
            default: legal_o = 1'b0;
        endcase
        if (!legal_o) begin
            alu_ctrl_o = ALU_ADD;
        end
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : IF/ID/EX/MEM/WB control FSM for the RV32I-subset datapath,
//               with instruction latch, memory stall and retired counter.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT_EN = 1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             Zero,
    input  logic             dReady,
    output logic             PCSrc,
    output logic             ALUSrc,
    output logic             RegWrite,
    output logic             MemToReg,
    output logic [3:0]       ALUCtrl,
    output logic             loadPC,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    state_e           state_q, state_d;
    logic [31:0]      ir_q, ir_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic [6:0] w_opcode;
    logic [3:0] w_dec_alu;
    logic       w_legal;
    logic       w_is_load;
    logic       w_is_store;
    logic       w_is_branch;
    logic       w_imm_op;
    logic       w_mem_ready;
    logic       w_unused_ir;

    assign w_opcode    = ir_q[6:0];
    assign w_is_load   = (w_opcode == OP_LOAD);
    assign w_is_store  = (w_opcode == OP_STORE);
    assign w_is_branch = (w_opcode == OP_BRANCH);
    assign w_imm_op    = (w_opcode == OP_I) || w_is_load || w_is_store;
    assign w_mem_ready = (MEM_WAIT_EN == 0) ? 1'b1 : dReady;
    assign w_unused_ir = ^{ir_q[31], ir_q[29:15], ir_q[11:7]};

    alu_decoder u_alu_decoder (
        .opcode_i   (w_opcode),
        .funct3_i   (ir_q[14:12]),
        .funct7b5_i (ir_q[30]),
        .alu_ctrl_o (w_dec_alu),
        .legal_o    (w_legal)
    );

    // Strobes are masked while rst is high so an aborted instruction has no side effects
    always_comb begin
        PCSrc    = 1'b0;
        ALUSrc   = 1'b0;
        RegWrite = 1'b0;
        MemToReg = 1'b0;
        ALUCtrl  = ALU_ADD;
        loadPC   = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        illegal  = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_ID: begin
                    ALUCtrl = w_dec_alu;
                    loadPC  = !w_legal;
                    illegal = !w_legal;
                end
                ST_EX: begin
                    ALUCtrl = w_dec_alu;
                    ALUSrc  = w_imm_op;
                    loadPC  = w_is_branch;
                    PCSrc   = w_is_branch && Zero;
                end
                ST_MEM: begin
                    ALUCtrl  = w_dec_alu;
                    ALUSrc   = w_imm_op;
                    MemRead  = w_is_load;
                    MemWrite = w_is_store;
                    loadPC   = w_is_store && w_mem_ready;
                end
                ST_WB: begin
                    ALUCtrl  = w_dec_alu;
                    ALUSrc   = w_imm_op;
                    RegWrite = 1'b1;
                    MemToReg = w_is_load;
                    loadPC   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        instret_d = instret_q;
        case (state_q)
            ST_IF: begin
                ir_d    = instr;
                state_d = ST_ID;
            end
            ST_ID:  state_d = w_legal ? ST_EX : ST_IF;
            ST_EX: begin
                if (w_is_branch) begin
                    state_d = ST_IF;
                end else if (w_is_load || w_is_store) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (w_mem_ready) begin
                    state_d = w_is_load ? ST_WB : ST_IF;
                end
            end
            ST_WB:   state_d = ST_IF;
            default: state_d = ST_IF;
        endcase
        // An illegal instruction's PC update happens in ID and does not retire
        if (loadPC && (state_q != ST_ID)) begin
            instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IF;
            ir_q      <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Directed per-cycle vector bench for multicycle_ctrl, plus a
//               no-wait / narrow-counter instance for MEM bypass and wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    localparam logic [31:0] G     = 32'hFFFF_FFFF;
    localparam logic [31:0] I_ADD = 32'h0020_81B3;
    localparam logic [31:0] I_SUB = 32'h4020_81B3;
    localparam logic [31:0] I_SRA = 32'h4020_D1B3;
    localparam logic [31:0] I_ADI = 32'h0050_0093;
    localparam logic [31:0] I_SRI = 32'h4030_D093;
    localparam logic [31:0] I_LW  = 32'h0081_2283;
    localparam logic [31:0] I_SW  = 32'h0051_2623;
    localparam logic [31:0] I_BEQ = 32'h0020_8463;
    localparam logic [31:0] I_SLU = 32'h0020_B1B3;

    // st bits: {PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite, illegal}
    typedef struct {
        logic [31:0] instr;
        logic        zero;
        logic        drdy;
        logic [3:0]  alu;
        logic [7:0]  st;
    } vec_t;

    logic        clk;
    logic        rst, rst2;
    logic [31:0] instr, instr2;
    logic        Zero, Zero2, dReady, dReady2;
    logic        PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite, illegal;
    logic        PCSrc2, ALUSrc2, RegWrite2, MemToReg2, loadPC2, MemRead2, MemWrite2, illegal2;
    logic [3:0]  ALUCtrl, ALUCtrl2;
    logic [31:0] instret;
    logic [1:0]  instret2;

    int   errors = 0;
    int   checks = 0;
    int   exp_cnt = 0;
    vec_t tbl[$];

    multicycle_ctrl #(.MEM_WAIT_EN(1), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .instr(instr), .Zero(Zero), .dReady(dReady),
        .PCSrc(PCSrc), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .MemToReg(MemToReg),
        .ALUCtrl(ALUCtrl), .loadPC(loadPC), .MemRead(MemRead), .MemWrite(MemWrite),
        .illegal(illegal), .instret(instret)
    );

    multicycle_ctrl #(.MEM_WAIT_EN(0), .CNT_W(2)) u_dut_nw (
        .clk(clk), .rst(rst2), .instr(instr2), .Zero(Zero2), .dReady(dReady2),
        .PCSrc(PCSrc2), .ALUSrc(ALUSrc2), .RegWrite(RegWrite2), .MemToReg(MemToReg2),
        .ALUCtrl(ALUCtrl2), .loadPC(loadPC2), .MemRead(MemRead2), .MemWrite(MemWrite2),
        .illegal(illegal2), .instret(instret2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [31:0] i, input logic z, input logic d,
                                input logic [3:0] a, input logic [7:0] s);
        vec_t v;
        v.instr = i; v.zero = z; v.drdy = d; v.alu = a; v.st = s;
        return v;
    endfunction

    task automatic push(input logic [31:0] i, input logic z, input logic d,
                        input logic [3:0] a, input logic [7:0] s);
        tbl.push_back(mk(i, z, d, a, s));
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    // Drive one cycle's inputs, compare at the falling edge, advance the model
    task automatic step(input vec_t v, input bit nw, input int idx);
        logic [7:0]  act_st;
        logic [3:0]  act_alu;
        logic [31:0] act_cnt, exp_c;
        if (nw) begin
            instr2 = v.instr; Zero2 = v.zero; dReady2 = v.drdy;
        end else begin
            instr = v.instr; Zero = v.zero; dReady = v.drdy;
        end
        @(negedge clk);
        if (nw) begin
            act_st  = {PCSrc2, ALUSrc2, RegWrite2, MemToReg2, loadPC2, MemRead2, MemWrite2, illegal2};
            act_alu = ALUCtrl2;
            act_cnt = {30'd0, instret2};
            exp_c   = exp_cnt & 32'h3;
        end else begin
            act_st  = {PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite, illegal};
            act_alu = ALUCtrl;
            act_cnt = instret;
            exp_c   = exp_cnt;
        end
        chk("strobes", idx, {24'd0, act_st}, {24'd0, v.st});
        chk("aluctrl", idx, {28'd0, act_alu}, {28'd0, v.alu});
        chk("instret", idx, act_cnt, exp_c);
        @(posedge clk);
        #1;
        if (v.st[3] && !v.st[0]) exp_cnt++;
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1;
        instr = '0; instr2 = '0;
        Zero = 1'b0; Zero2 = 1'b0; dReady = 1'b0; dReady2 = 1'b0;

        // add, sub (Zero high must not leak into PCSrc), sra
        push(I_ADD, 0, 1, 4'b0010, 8'h00); push(G, 0, 1, 4'b0010, 8'h00);
        push(G, 0, 1, 4'b0010, 8'h00);     push(G, 0, 1, 4'b0010, 8'h28);
        push(I_SUB, 1, 1, 4'b0010, 8'h00); push(G, 1, 1, 4'b0110, 8'h00);
        push(G, 1, 1, 4'b0110, 8'h00);     push(G, 1, 1, 4'b0110, 8'h28);
        push(I_SRA, 0, 1, 4'b0010, 8'h00); push(G, 0, 1, 4'b1010, 8'h00);
        push(G, 0, 1, 4'b1010, 8'h00);     push(G, 0, 1, 4'b1010, 8'h28);
        // addi, srai
        push(I_ADI, 0, 1, 4'b0010, 8'h00); push(G, 0, 1, 4'b0010, 8'h00);
        push(G, 0, 1, 4'b0010, 8'h40);     push(G, 0, 1, 4'b0010, 8'h68);
        push(I_SRI, 0, 1, 4'b0010, 8'h00); push(G, 0, 1, 4'b1010, 8'h00);
        push(G, 0, 1, 4'b1010, 8'h40);     push(G, 0, 1, 4'b1010, 8'h68);
        // lw with two wait cycles
        push(I_LW, 0, 1, 4'b0010, 8'h00);  push(G, 0, 1, 4'b0010, 8'h00);
        push(G, 0, 1, 4'b0010, 8'h40);     push(G, 0, 0, 4'b0010, 8'h44);
        push(G, 0, 0, 4'b0010, 8'h44);     push(G, 0, 1, 4'b0010, 8'h44);
        push(G, 0, 1, 4'b0010, 8'h78);
        // sw ready at once, then sw with one wait
        push(I_SW, 0, 1, 4'b0010, 8'h00);  push(G, 0, 1, 4'b0010, 8'h00);
        push(G, 0, 1, 4'b0010, 8'h40);     push(G, 0, 1, 4'b0010, 8'h4A);
        push(I_SW, 0, 0, 4'b0010, 8'h00);  push(G, 0, 0, 4'b0010, 8'h00);
        push(G, 0, 0, 4'b0010, 8'h40);     push(G, 0, 0, 4'b0010, 8'h42);
        push(G, 0, 1, 4'b0010, 8'h4A);
        // beq taken / not taken
        push(I_BEQ, 1, 1, 4'b0010, 8'h00); push(G, 1, 1, 4'b0110, 8'h00);
        push(G, 1, 1, 4'b0110, 8'h88);
        push(I_BEQ, 0, 1, 4'b0010, 8'h00); push(G, 0, 1, 4'b0110, 8'h00);
        push(G, 0, 1, 4'b0110, 8'h08);
        // illegal opcode, illegal funct3 (sltu), then a legal add
        push(G, 0, 1, 4'b0010, 8'h00);     push(G, 0, 1, 4'b0010, 8'h09);
        push(I_SLU, 0, 1, 4'b0010, 8'h00); push(G, 0, 1, 4'b0010, 8'h09);
        push(I_ADD, 0, 1, 4'b0010, 8'h00); push(G, 0, 1, 4'b0010, 8'h00);
        push(G, 0, 1, 4'b0010, 8'h00);     push(G, 0, 1, 4'b0010, 8'h28);

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_strobes", 0,
            {24'd0, PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite, illegal}, 32'd0);
        chk("reset_aluctrl", 0, {28'd0, ALUCtrl}, 32'h2);
        chk("reset_instret", 0, instret, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b0, i);

        // Reset during the MEM cycle of a store: no write, no PC update
        step(mk(I_SW, 0, 1, 4'b0010, 8'h00), 1'b0, 100);
        step(mk(G, 0, 1, 4'b0010, 8'h00), 1'b0, 101);
        step(mk(G, 0, 1, 4'b0010, 8'h40), 1'b0, 102);
        dReady = 1'b1;
        rst    = 1'b1;
        @(negedge clk);
        chk("rst_abort_strobes", 103,
            {24'd0, PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite, illegal}, 32'd0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        exp_cnt = 0;
        step(mk(I_ADD, 0, 1, 4'b0010, 8'h00), 1'b0, 104);
        step(mk(G, 0, 1, 4'b0010, 8'h00), 1'b0, 105);
        step(mk(G, 0, 1, 4'b0010, 8'h00), 1'b0, 106);
        step(mk(G, 0, 1, 4'b0010, 8'h28), 1'b0, 107);

        // No-wait instance: MEM ignores dReady; 2-bit counter wraps after four retirements
        exp_cnt = 0;
        rst2    = 1'b0;
        step(mk(I_LW, 0, 0, 4'b0010, 8'h00), 1'b1, 200);
        step(mk(G, 0, 0, 4'b0010, 8'h00), 1'b1, 201);
        step(mk(G, 0, 0, 4'b0010, 8'h40), 1'b1, 202);
        step(mk(G, 0, 0, 4'b0010, 8'h44), 1'b1, 203);
        step(mk(G, 0, 0, 4'b0010, 8'h78), 1'b1, 204);
        for (int k = 0; k < 3; k++) begin
            step(mk(I_BEQ, 0, 0, 4'b0010, 8'h00), 1'b1, 210 + 3 * k);
            step(mk(G, 0, 0, 4'b0110, 8'h00), 1'b1, 211 + 3 * k);
            step(mk(G, 0, 0, 4'b0110, 8'h08), 1'b1, 212 + 3 * k);
        end
        @(negedge clk);
        chk("instret_wrap", 300, {30'd0, instret2}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multicycle control FSM for the RV32I-subset processor. It sits directly upstream of the datapath and drives all of the datapath's control strobes: PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl and loadPC. It also drives the data-memory read/write strobes. It latches the fetched instruction, sequences IF/ID/EX/MEM/WB, stalls on data-memory ready, and counts retired instructions.

Parameters:
- MEM_WAIT_EN, 1, when 1 the MEM state waits for dReady; when 0 MEM always lasts exactly one cycle.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  32  instruction word from instruction memory; valid in IF.
- Zero  in  1  ALU zero flag from the datapath; sampled in EX.
- dReady  in  1  data memory done; meaningful only in MEM.
- PCSrc  out  1  1 = take branch target.
- ALUSrc  out  1  1 = immediate operand, 0 = rs2.
- RegWrite  out  1  register-file write enable.
- MemToReg  out  1  1 = writeback from memory.
- ALUCtrl  out  4  ALU operation code.
- loadPC  out  1  PC update strobe, one cycle per instruction.
- MemRead  out  1  data-memory read strobe.
- MemWrite  out  1  data-memory write strobe.
- illegal  out  1  one-cycle pulse on an unsupported opcode/funct.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Reset: clk and rst as in the codebase; reset is synchronous and active-high.
  - state=IF, IR=0, instret=0, illegal=0.
  - All strobes 0; ALUCtrl=ADD (4'b0010).
  - rst mid-instruction aborts it: no loadPC, RegWrite or MemWrite in the reset cycle or after it.
- IR latch: IR<=instr on the IF->ID edge only. All decode uses IR, never live instr.
- Supported instructions:
  - R-type: add, sub, and, or, xor, slt, sll, srl, sra.
  - I-ALU: addi, andi, ori, xori, slti, slli, srli, srai.
  - Memory: lw, sw.
  - Branch: beq.
  - Everything else is illegal.
- ALUCtrl encoding: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SRL 1000, SLL 1001, SRA 1010, XOR 1101.
  - Decode: R uses funct3 plus funct7[5]. I uses funct3; funct7[5] is checked only for srli/srai.
  - lw/sw use ADD; beq uses SUB.
- State transitions (one state per cycle):
  - IF->ID.
  - ID->EX if legal. If illegal, ID->IF with loadPC=1, PCSrc=0 and an illegal pulse; instret is not incremented.
  - EX: R/I-ALU go to WB; lw/sw go to MEM; beq goes to IF.
  - MEM: lw goes to WB when dReady; sw goes to IF when dReady. With dReady=0 the FSM stays in MEM and holds the strobes.
  - WB->IF.
- Output decode is combinational from state and IR (Moore + IR):
  - ALUSrc=1 in EX/MEM/WB for I-ALU, lw and sw.
  - ALUCtrl is valid from ID through the last state of the instruction. In IF it is ADD.
  - MemRead=1 in MEM for lw; MemWrite=1 in MEM for sw.
  - RegWrite=1 in WB only. MemToReg=1 in WB for lw.
  - loadPC=1 in exactly one cycle per instruction:
    - WB for R/I/lw.
    - The dReady cycle of MEM for sw.
    - EX for beq.
    - ID for illegal.
  - PCSrc = (beq in EX) & Zero. It is 0 in every other cycle.
- Latencies: R/I = 4 cycles, lw = 5+waits, sw = 4+waits, beq = 3, illegal = 2.
- instret increments by 1 on every loadPC cycle of a legal instruction. It wraps modulo 2^CNT_W with no saturation.
- MEM_WAIT_EN=0: dReady is ignored and treated as 1.
- rs1/rs2/rd fields are not outputs; the datapath extracts them.

Decomposition:
- ctrl_pkg holds:
  - opcode constants: OP_R 0110011, OP_I 0010011, OP_LOAD 0000011, OP_STORE 0100011, OP_BRANCH 1100011.
  - the ALUCtrl codes.
  - the state enum (IF, ID, EX, MEM, WB).
- One sub-module, alu_decoder: combinational map from opcode/funct3/funct7[5] to ALUCtrl and a legal flag.

Test Plan:
- Reset, then add x3,x1,x2 (0x002081B3) -> ALUCtrl=0010 in ID/EX/WB; RegWrite=1 and loadPC=1 only in cycle 4; ALUSrc=0; instret=1.
- sub (0x402081B3) -> ALUCtrl=0110. addi x1,x0,5 (0x00500093) -> ALUSrc=1, ALUCtrl=0010, RegWrite in WB.
- lw x5,8(x2) (0x00812283) with dReady low for 2 cycles -> MemRead=1 held for 3 MEM cycles; then WB with MemToReg=1, RegWrite=1, loadPC=1; total 7 cycles.
- sw x5,12(x2) (0x00512623), dReady=1 -> MemWrite=1 and loadPC=1 together in cycle 4; RegWrite never asserted.
- beq x1,x2,+8 (0x00208463): Zero=1 in EX -> PCSrc=1, loadPC=1 in cycle 3. Repeat with Zero=0 -> PCSrc=0, loadPC=1.
- 0xFFFFFFFF -> illegal pulse and loadPC in cycle 2; instret unchanged. rst asserted in MEM of an sw -> no MemWrite; state=IF next cycle.
